button_event_arbiter: RTL and testbench



---
 rtl/button_arb_pkg.sv | 42 ++++
 rtl/button_event_arbiter_rr_picker.sv | 37 +++
 rtl/button_event_arbiter.sv | 112 +++++++++++
 tb/tb_button_event_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/button_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : button_arb_pkg
// Purpose  : Shared types and the priority-pick helper for button_event_arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package button_arb_pkg;

  localparam int MAX_WIDTH = 16;

  typedef logic [3:0] btn_idx_t;

  typedef struct packed {
    logic     valid;
    btn_idx_t idx;
  } pick_t;

  // The first requester found scanning upward from start (wrapping at width)
  // wins. The scan runs backwards so the last hit written is the first in order.
  function automatic pick_t arb_pick(input logic [MAX_WIDTH-1:0] req,
                                     input btn_idx_t             start,
                                     input int                   width);
    pick_t p;
    int    idx;
    p = '0;
    for (int k = MAX_WIDTH - 1; k >= 0; k--) begin
      if (k < width) begin
        idx = int'(start) + k;
        if (idx >= width) idx = idx - width;
        if (req[idx[3:0]]) begin
          p.valid = 1'b1;
          p.idx   = btn_idx_t'(idx);
        end
      end
    end
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_event_arbiter_rr_picker.sv
//------------------------------------------------------------------------------
// Module   : rr_picker
// Purpose  : Combinational request picker; rotating start in round-robin mode,
//            start pinned to index 0 in fixed-priority mode.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_picker
  import button_arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_req,
  input  btn_idx_t         i_start,
  input  logic             i_rr_mode,
  output logic             o_valid,
  output btn_idx_t         o_idx
);

  logic [MAX_WIDTH-1:0] w_req_ext;
  btn_idx_t             w_start;
  pick_t                w_pick;

  always_comb begin
    w_req_ext              = '0;
    w_req_ext[WIDTH-1:0]   = i_req;
    w_start                = i_rr_mode ? i_start : '0;
    w_pick                 = arb_pick(w_req_ext, w_start, WIDTH);
  end

  assign o_valid = w_pick.valid;
  assign o_idx   = w_pick.idx;

endmodule

`default_nettype wire

// File: rtl/button_event_arbiter.sv
//------------------------------------------------------------------------------
// Module   : button_event_arbiter
// Purpose  : Queues button press pulses in per-button counters and serializes
//            them onto a valid/ready command stream. Define
//            BUTTON_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module button_event_arbiter
  import button_arb_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int MAX_PENDING = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         i_btn_pulse,
  output logic                     o_cmd_valid,
  input  logic                     i_cmd_ready,
  output logic [$clog2(WIDTH)-1:0] o_cmd_id,
  output logic                     o_pending_any,
  output logic                     o_overflow
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(MAX_PENDING + 1);
  localparam logic [CNT_W-1:0] c_MAX = CNT_W'(MAX_PENDING);

  logic             r_cmd_valid;
  logic [IDX_W-1:0] r_cmd_id;
  logic             r_overflow;

  logic [WIDTH-1:0] w_req;
  logic [WIDTH-1:0] w_drop;
  logic             w_slot_free;
  logic             w_pick_valid;
  btn_idx_t         w_pick_idx;
  logic             w_grant;
  btn_idx_t         w_start;
  logic             w_rr_mode;
  logic             w_unused_idx;

  assign w_slot_free  = !r_cmd_valid || i_cmd_ready;
  assign w_grant      = w_slot_free && w_pick_valid;
  assign w_unused_idx = ^w_pick_idx;

`ifdef BUTTON_ARB_ROUND_ROBIN_EN
  btn_idx_t r_last;

  assign w_rr_mode = 1'b1;
  assign w_start   = (r_last == btn_idx_t'(WIDTH - 1)) ? '0 : r_last + 4'd1;

  always_ff @(posedge clk) begin
    if (rst)          r_last <= btn_idx_t'(WIDTH - 1);
    else if (w_grant) r_last <= w_pick_idx;
  end
`else
  assign w_rr_mode = 1'b0;
  assign w_start   = '0;
`endif

  rr_picker #(
    .WIDTH     (WIDTH)
  ) u_picker (
    .i_req     (w_req),
    .i_start   (w_start),
    .i_rr_mode (w_rr_mode),
    .o_valid   (w_pick_valid),
    .o_idx     (w_pick_idx)
  );

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pend
    logic [CNT_W-1:0] r_cnt;
    logic             w_inc;
    logic             w_dec;

    assign w_inc      = i_btn_pulse[gi];
    assign w_dec      = w_grant && (w_pick_idx == btn_idx_t'(gi));
    assign w_drop[gi] = w_inc && !w_dec && (r_cnt == c_MAX);
    assign w_req[gi]  = (r_cnt != '0);

    // A pulse and a grant in the same cycle cancel out.
    always_ff @(posedge clk) begin
      if (rst)                                  r_cnt <= '0;
      else if (w_inc && !w_dec && !w_drop[gi])  r_cnt <= r_cnt + 1'b1;
      else if (w_dec && !w_inc)                 r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_valid <= 1'b0;
      r_cmd_id    <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_overflow <= r_overflow | (|w_drop);
      if (w_slot_free) begin
        r_cmd_valid <= w_grant;
        if (w_grant) r_cmd_id <= w_pick_idx[IDX_W-1:0];
      end
    end
  end

  assign o_cmd_valid   = r_cmd_valid;
  assign o_cmd_id      = r_cmd_id;
  assign o_pending_any = |w_req;
  assign o_overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_button_event_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_button_event_arbiter
// Purpose  : Directed self-checking bench for button_event_arbiter (WIDTH=4,
//            MAX_PENDING=3); expectations follow BUTTON_ARB_ROUND_ROBIN_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_button_event_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_pulse = '0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [1:0] cmd_id;
  logic       pending_any;
  logic       overflow;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  button_event_arbiter #(
    .WIDTH         (4),
    .MAX_PENDING   (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_btn_pulse   (btn_pulse),
    .o_cmd_valid   (cmd_valid),
    .i_cmd_ready   (cmd_ready),
    .o_cmd_id      (cmd_id),
    .o_pending_any (pending_any),
    .o_overflow    (overflow)
  );

  typedef struct {
    logic       rst;
    logic [3:0] pulse;
    logic       ready;
    logic       ev;
    logic [1:0] eid;
    logic       epa;
    logic       eov;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(input logic r, input logic [3:0] p, input logic rd,
                              input logic ev, input logic [1:0] eid,
                              input logic epa, input logic eov);
    vec_t v;
    v.rst = r; v.pulse = p; v.ready = rd;
    v.ev = ev; v.eid = eid; v.epa = epa; v.eov = eov;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic step(input logic r, input logic [3:0] p, input logic rd);
    rst       = r;
    btn_pulse = p;
    cmd_ready = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs;
    // Single press, then pulse coinciding with its own grant.
    tbl[0]  = mk(1, 4'b0000, 1, 0, 0, 0, 0);
    tbl[1]  = mk(0, 4'b0100, 1, 0, 0, 1, 0);
    tbl[2]  = mk(0, 4'b0000, 1, 1, 2, 0, 0);
    tbl[3]  = mk(0, 4'b0000, 1, 0, 0, 0, 0);
    tbl[4]  = mk(0, 4'b1000, 1, 0, 0, 1, 0);
    tbl[5]  = mk(0, 4'b1000, 1, 1, 3, 1, 0);
    tbl[6]  = mk(0, 4'b0000, 1, 1, 3, 0, 0);
    tbl[7]  = mk(0, 4'b0000, 1, 0, 0, 0, 0);
    // One press on every button: same order in both policies.
    tbl[8]  = mk(0, 4'b1111, 1, 0, 0, 1, 0);
    tbl[9]  = mk(0, 4'b0000, 1, 1, 0, 1, 0);
    tbl[10] = mk(0, 4'b0000, 1, 1, 1, 1, 0);
    tbl[11] = mk(0, 4'b0000, 1, 1, 2, 1, 0);
    tbl[12] = mk(0, 4'b0000, 1, 1, 3, 0, 0);
    tbl[13] = mk(0, 4'b0000, 1, 0, 0, 0, 0);
    // Two presses on buttons 0 and 3; first grant lands on the second pulse edge.
    tbl[14] = mk(0, 4'b1001, 1, 0, 0, 1, 0);
    tbl[15] = mk(0, 4'b1001, 1, 1, 0, 1, 0);
`ifdef BUTTON_ARB_ROUND_ROBIN_EN
    tbl[16] = mk(0, 4'b0000, 1, 1, 3, 1, 0);
    tbl[17] = mk(0, 4'b0000, 1, 1, 0, 1, 0);
`else
    tbl[16] = mk(0, 4'b0000, 1, 1, 0, 1, 0);
    tbl[17] = mk(0, 4'b0000, 1, 1, 3, 1, 0);
`endif
    tbl[18] = mk(0, 4'b0000, 1, 1, 3, 0, 0);
    tbl[19] = mk(0, 4'b0000, 1, 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].rst, tbl[i].pulse, tbl[i].ready);
      if (i == 0) chk("reset_id", {30'd0, cmd_id}, 0);
      chk($sformatf("vec%0d_valid", i), {31'd0, cmd_valid}, {31'd0, tbl[i].ev});
      if (tbl[i].ev) chk($sformatf("vec%0d_id", i), {30'd0, cmd_id}, {30'd0, tbl[i].eid});
      chk($sformatf("vec%0d_pend_any", i), {31'd0, pending_any}, {31'd0, tbl[i].epa});
      chk($sformatf("vec%0d_overflow", i), {31'd0, overflow}, {31'd0, tbl[i].eov});
    end

    // Backpressure: three presses on button 1, consumer stalled.
    step(1, 4'b0000, 0);
    for (int k = 0; k < 3; k++) step(0, 4'b0010, 0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", {31'd0, cmd_valid}, 1);
      chk("bp_hold_id", {30'd0, cmd_id}, 1);
      step(0, 4'b0000, 0);
    end
    hs = 0;
    for (int k = 0; k < 8; k++) begin
      if (cmd_valid) begin
        hs++;
        chk("bp_hs_id", {30'd0, cmd_id}, 1);
      end
      step(0, 4'b0000, 1);
    end
    chk("bp_hs_count", hs, 3);
    chk("bp_end_valid", {31'd0, cmd_valid}, 0);

    // Saturation: five presses on button 0; one sits in the slot, three queue, one drops.
    step(1, 4'b0000, 0);
    for (int k = 1; k <= 5; k++) begin
      step(0, 4'b0001, 0);
      chk($sformatf("sat_ovf_after_%0d", k), {31'd0, overflow}, (k == 5) ? 1 : 0);
    end
    chk("sat_valid", {31'd0, cmd_valid}, 1);
    chk("sat_id", {30'd0, cmd_id}, 0);
    hs = 0;
    for (int k = 0; k < 10; k++) begin
      if (cmd_valid) hs++;
      step(0, 4'b0000, 1);
    end
    chk("sat_hs_count", hs, 4);
    chk("sat_ovf_sticky", {31'd0, overflow}, 1);

    // Reset mid-stream with a command presented and button 2 still queued.
    for (int k = 0; k < 3; k++) step(0, 4'b0100, 0);
    chk("rstm_pre_valid", {31'd0, cmd_valid}, 1);
    chk("rstm_pre_id", {30'd0, cmd_id}, 2);
    step(1, 4'b0100, 1);
    chk("rstm_valid", {31'd0, cmd_valid}, 0);
    chk("rstm_id", {30'd0, cmd_id}, 0);
    chk("rstm_pend_any", {31'd0, pending_any}, 0);
    chk("rstm_overflow", {31'd0, overflow}, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 4'b0000, 1);
      chk("rstm_quiet_valid", {31'd0, cmd_valid}, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
